// File: rtl/prog_loader.sv
// Framed byte-stream loader that fills the pipeline instruction memory word by word.
// Latency: write strobe one cycle after the 4th byte of a word; start rises one cycle after load_req.
// Backpressure: in_ready high only while loading (HDR/DATA/CKSUM); stalls on in_valid=0 are tolerated.
//
// Ports:
//   clk, rst            - single clock, synchronous active-high reset
//   load_req            - begin a load (honoured in IDLE and ERR)
//   in_valid/in_data    - input byte stream, transfer on in_valid & in_ready
//   in_ready            - loader accepts a byte this cycle
//   start               - held high while loading (pipeline load port)
//   wr_en/address/instruction - one-cycle memory write of an assembled word
//   busy, done, err     - status: loading, one-cycle completion pulse, sticky error
// Optional feature macro: PROG_LOADER_CKSUM_EN adds a trailing XOR checksum byte check.

module prog_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          start,
    output logic          wr_en,
    output logic [AW-1:0] address,
    output logic [31:0]   instruction,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
`ifdef PROG_LOADER_CKSUM_EN
        S_CKSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      nxt;

    logic [1:0]  bcnt;       // byte position within the current 4-byte group
    logic [23:0] hdr_part;   // first three header bytes
    logic [31:0] n_words;    // word count from the header
    logic [23:0] data_part;  // first three bytes of the word being assembled
    logic [31:0] wcnt;       // words written so far
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0]  xor_acc;    // running XOR over payload bytes
`endif

    logic        acc;
    logic        last_byte;
    logic [31:0] n_next;
    logic [31:0] w_next;
    logic        busy_n;
    logic        restart;

    assign acc       = in_valid & in_ready;
    assign last_byte = (bcnt == 2'd3);
    // Little-endian: the 4th byte lands in bits 31:24.
    assign n_next    = {in_data, hdr_part};
    assign w_next    = {in_data, data_part};
    assign restart   = load_req & ((state == S_IDLE) | (state == S_ERR));

    // Next-state decode; outputs are registered from this in the sequential block.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: if (load_req) nxt = S_HDR;
            S_HDR: begin
                if (acc && last_byte) begin
                    if (n_next == 32'd0) begin
`ifdef PROG_LOADER_CKSUM_EN
                        nxt = S_CKSUM;
`else
                        nxt = S_DONE;
`endif
                    end else if (n_next > 32'(DEPTH)) begin
                        nxt = S_ERR;
                    end else begin
                        nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc && last_byte && (wcnt == n_words - 32'd1)) begin
`ifdef PROG_LOADER_CKSUM_EN
                    nxt = S_CKSUM;
`else
                    nxt = S_DONE;
`endif
                end
            end
`ifdef PROG_LOADER_CKSUM_EN
            S_CKSUM: if (acc) nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
`endif
            S_DONE: nxt = S_IDLE;
            S_ERR:  if (load_req) nxt = S_HDR;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_n = (nxt == S_HDR) || (nxt == S_DATA);
`ifdef PROG_LOADER_CKSUM_EN
        if (nxt == S_CKSUM) busy_n = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            in_ready    <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            wr_en       <= 1'b0;
            address     <= '0;
            instruction <= '0;
            bcnt        <= '0;
            hdr_part    <= '0;
            n_words     <= '0;
            data_part   <= '0;
            wcnt        <= '0;
`ifdef PROG_LOADER_CKSUM_EN
            xor_acc     <= '0;
`endif
        end else begin
            state    <= nxt;
            in_ready <= busy_n;
            start    <= busy_n;
            busy     <= busy_n;
            done     <= (nxt == S_DONE);
            // err is sticky: held in ERR, cleared only by the load_req that leaves it.
            err      <= (nxt == S_ERR);
            wr_en    <= 1'b0;

            if (restart) begin
                bcnt <= '0;
                wcnt <= '0;
`ifdef PROG_LOADER_CKSUM_EN
                xor_acc <= '0;
`endif
            end

            if (acc && (state == S_HDR)) begin
                bcnt     <= bcnt + 2'd1;
                hdr_part <= n_next[31:8];
                if (last_byte) n_words <= n_next;
            end

            if (acc && (state == S_DATA)) begin
                bcnt      <= bcnt + 2'd1;
                data_part <= w_next[31:8];
`ifdef PROG_LOADER_CKSUM_EN
                xor_acc   <= xor_acc ^ in_data;
`endif
                if (last_byte) begin
                    wr_en       <= 1'b1;
                    address     <= AW'(wcnt);
                    instruction <= w_next;
                    wcnt        <= wcnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_req = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, start, wr_en, busy, done, err;
    logic [AW-1:0] address;
    logic [31:0]   instruction;

    prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .load_req(load_req),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .start(start), .wr_en(wr_en), .address(address),
        .instruction(instruction), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the frame by byte index: 0..3 header, then 4*N payload, then optional checksum.
    bit          m_busy = 0, m_err = 0;
    bit          e_wr = 0, e_done = 0, cur_done;
    logic [31:0] e_addr = 0, e_instr = 0;
    logic [31:0] m_n = 0;
    logic [7:0]  wb [4];
    logic [7:0]  xr = 0;
    longint      k = 0, p;

    // DUT activity log for directed literal checks
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          done_cnt = 0;

    task automatic payload_end();
`ifndef PROG_LOADER_CKSUM_EN
        m_busy = 0;
        e_done = 1;
`endif
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cur_done = e_done;
            e_wr = 0;
            e_done = 0;
            if (rst) begin
                m_busy = 0; m_err = 0; e_addr = 0; e_instr = 0;
            end else if (load_req && !m_busy && !cur_done) begin
                m_busy = 1; m_err = 0; k = 0; xr = 0; m_n = 0;
            end else if (m_busy && in_valid) begin
                if (k < 4) begin
                    m_n[8*k +: 8] = in_data;
                    if (k == 3) begin
                        if (m_n == 0) payload_end();
                        else if (m_n > DEPTH) begin m_busy = 0; m_err = 1; end
                    end
                end else if (k - 4 < 4 * longint'(m_n)) begin
                    p = k - 4;
                    wb[p % 4] = in_data;
                    xr ^= in_data;
                    if (p % 4 == 3) begin
                        e_wr = 1;
                        e_addr = 32'(p / 4);
                        e_instr = {wb[3], wb[2], wb[1], wb[0]};
                        if (p == 4 * longint'(m_n) - 1) payload_end();
                    end
                end else begin
                    m_busy = 0;
                    if (in_data == xr) e_done = 1;
                    else m_err = 1;
                end
                k++;
            end
            #1;
            chk("in_ready", in_ready, m_busy);
            chk("start", start, m_busy);
            chk("busy", busy, m_busy);
            chk("wr_en", wr_en, e_wr);
            chk("done", done, e_done);
            chk("err", err, m_err);
            chk("address", address, e_addr);
            chk("instruction", instruction, e_instr);
            if (wr_en) begin
                wr_addr_q.push_back(address);
                wr_data_q.push_back(instruction);
            end
            if (done) done_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] fw[$];

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt = 0;
    endtask

    // Entered and left at a negedge; holds the byte until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        in_data  = b;
        in_valid = 1'b1;
        load_req = in_ready && ($urandom_range(0, 7) == 0); // ignored while busy
        t = 0;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("byte_accept_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        load_req = 1'b0;
    endtask

    task automatic gap(input int lo, input int hi);
        repeat ($urandom_range(lo, hi)) @(negedge clk);
    endtask

    task automatic junk(input int n);
        repeat (n) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] n, input int glo, input int ghi, input bit bad_ck);
        logic [7:0]  x;
        logic [31:0] w;
        pulse_load();
        for (int i = 0; i < 4; i++) begin
            gap(glo, ghi);
            send_byte(n[8*i +: 8]);
        end
        if (n <= DEPTH) begin
            x = 8'h00;
            for (int wi = 0; wi < int'(n); wi++) begin
                w = fw[wi];
                for (int b = 0; b < 4; b++) begin
                    gap(glo, ghi);
                    x ^= w[8*b +: 8];
                    send_byte(w[8*b +: 8]);
                end
            end
`ifdef PROG_LOADER_CKSUM_EN
            gap(glo, ghi);
            send_byte(bad_ck ? (x ^ 8'h01) : x);
`else
            if (bad_ck) junk(2);   // trailing bytes must not be taken
`endif
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: N=2, continuous
        fw = '{32'h00500093, 32'h00A00113};
        clear_log();
        run_frame(2, 0, 0, 1);
        chk("n2_wr_count", wr_addr_q.size(), 2);
        if (wr_addr_q.size() == 2) begin
            chk("n2_addr0", wr_addr_q[0], 0);
            chk("n2_data0", wr_data_q[0], 32'h00500093);
            chk("n2_addr1", wr_addr_q[1], 1);
            chk("n2_data1", wr_data_q[1], 32'h00A00113);
        end
        chk("n2_done_cnt", done_cnt, 1);
        chk("n2_start_after", start, 0);
        chk("n2_err", err, 0);

        // Same frame with 3 idle cycles between bytes
        clear_log();
        run_frame(2, 3, 3, 0);
        chk("gap_wr_count", wr_addr_q.size(), 2);
        if (wr_data_q.size() == 2) chk("gap_data1", wr_data_q[1], 32'h00A00113);
        chk("gap_done_cnt", done_cnt, 1);

`ifndef PROG_LOADER_CKSUM_EN
        // N=0: done the cycle after the 4th header byte
        clear_log();
        pulse_load();
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        chk("n0_done_now", done, 1);
        chk("n0_start_now", start, 0);
        repeat (2) @(negedge clk);
        chk("n0_wr_count", wr_addr_q.size(), 0);
        chk("n0_done_cnt", done_cnt, 1);
`else
        // N=1, 0x12345678: good checksum 0x08, then bad checksum
        fw = '{32'h12345678};
        clear_log();
        run_frame(1, 0, 1, 0);
        chk("ck_done_cnt", done_cnt, 1);
        chk("ck_err", err, 0);
        clear_log();
        run_frame(1, 0, 1, 1);
        chk("ckbad_done_cnt", done_cnt, 0);
        chk("ckbad_err", err, 1);
`endif

        // Oversize header
        clear_log();
        run_frame(1025, 0, 1, 0);
        chk("big_err", err, 1);
        chk("big_start", start, 0);
        chk("big_wr_count", wr_addr_q.size(), 0);
        fw = '{32'hCAFEF00D};
        run_frame(1, 0, 0, 0);
        chk("big_recover_err", err, 0);
        chk("big_recover_done", done_cnt, 1);

        // Reset after 6 payload bytes of N=3
        clear_log();
        pulse_load();
        send_byte(8'd3); send_byte(8'd0); send_byte(8'd0); send_byte(8'd0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_start", start, 0);
        chk("rst_wr_count", wr_addr_q.size(), 1);
        if (wr_addr_q.size() == 1) chk("rst_data0", wr_data_q[0], 32'h13121110);
        fw = '{32'h11111111, 32'h22222222};
        clear_log();
        run_frame(2, 0, 1, 0);
        chk("rst_fresh_done", done_cnt, 1);
        chk("rst_fresh_wr", wr_addr_q.size(), 2);

        // Randomised frames, idle junk between them
        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(0, 6);
            if ($urandom_range(0, 9) == 0) n = 1025 + $urandom_range(0, 3);
            fw.delete();
            for (int i = 0; i < 6; i++) fw.push_back($urandom);
            run_frame(32'(n), 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
            junk($urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
